// File: rtl/hex_count_ctrl.sv
// Start/hold/clear controlled 4-bit up/down counter feeding a hex seven-segment decoder.
// A prescaler paces count steps; Co flags a wrap and one_shot stops after the first wrap.
module hex_count_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       up_down,
    input  logic       one_shot,
    output logic [3:0] Count_out,
    output logic       Co,
    output logic       running
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          start_q_r;
    logic          stop_q_r;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic [3:0]    count_s;
    logic          start_e_s;
    logic          stop_e_s;
    logic          tick_s;
    logic          wrap_s;

    assign start_e_s = start & ~start_q_r;
    assign stop_e_s  = stop & ~stop_q_r;
    // A stop edge or a load swallows the tick that would otherwise land this cycle.
    assign tick_s    = (state_r == RUN) && (presc_r == PRESC_TOP) && !stop_e_s && !load;
    assign wrap_s    = tick_s && (up_down ? (Count_out == 4'hF) : (Count_out == 4'h0));

    // State register plus button edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            start_q_r <= 1'b0;
            stop_q_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            start_q_r <= start;
            stop_q_r  <= stop;
        end
    end

    // Next-state logic; stop outranks start when both edges coincide.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (stop_e_s)       state_s = IDLE;
                else if (start_e_s) state_s = RUN;
                else                state_s = IDLE;
            end
            RUN: begin
                if (stop_e_s)                state_s = HOLD;
                else if (wrap_s && one_shot) state_s = IDLE;
                else                         state_s = RUN;
            end
            HOLD: begin
                if (stop_e_s)       state_s = IDLE;
                else if (start_e_s) state_s = RUN;
                else                state_s = HOLD;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next count and prescaler values; load overrides everything else.
    always_comb begin
        count_s = Count_out;
        presc_s = presc_r;
        if (load) begin
            count_s = load_val;
            presc_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    presc_s = '0;
                    if (stop_e_s) count_s = 4'h0;
                    else          count_s = Count_out;
                end
                RUN: begin
                    if (stop_e_s) begin
                        presc_s = presc_r;
                    end else if (tick_s) begin
                        presc_s = '0;
                        count_s = up_down ? (Count_out + 4'h1) : (Count_out - 4'h1);
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                end
                HOLD: begin
                    if (stop_e_s) begin
                        count_s = 4'h0;
                        presc_s = '0;
                    end else begin
                        count_s = Count_out;
                        presc_s = presc_r;
                    end
                end
                default: begin
                    count_s = 4'h0;
                    presc_s = '0;
                end
            endcase
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Count_out <= 4'h0;
            presc_r   <= '0;
            Co        <= 1'b0;
            running   <= 1'b0;
        end else begin
            Count_out <= count_s;
            presc_r   <= presc_s;
            Co        <= wrap_s;
            running   <= (state_s == RUN);
        end
    end

endmodule

// File: tb/tb_hex_count_ctrl.sv
// Scoreboard bench for hex_count_ctrl: a behavioural model queues expected outputs per clock,
// and a negedge monitor pops and compares them against the DUT.
module tb_hex_count_ctrl;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, load, up_down, one_shot;
    logic [3:0] load_val;
    logic [3:0] Count_out;
    logic       Co, running;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cnt;
        int co;
        int run;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model: mode 0 idle, 1 run, 2 hold
    int m_mode, m_count, m_phase, m_co, m_prev_start, m_prev_stop;

    hex_count_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .up_down(up_down), .one_shot(one_shot),
        .Count_out(Count_out), .Co(Co), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_phase = 0; m_co = 0;
        m_prev_start = 0; m_prev_stop = 0;
    endtask

    // One clock of the model, from the inputs as they stand at the edge.
    task automatic model_step();
        bit se, pe;
        int nmode;
        exp_t e;
        se = start && !m_prev_start;
        pe = stop && !m_prev_stop;
        m_prev_start = start;
        m_prev_stop  = stop;
        m_co  = 0;
        nmode = m_mode;
        if (m_mode == 0) begin
            m_phase = 0;
            if (pe) m_count = 0;
            else if (se) nmode = 1;
        end else if (m_mode == 1) begin
            if (pe) nmode = 2;
            else if (m_phase == PRESCALE - 1 && !load) begin
                m_phase = 0;
                m_count = up_down ? (m_count + 1) % 16 : (m_count + 15) % 16;
                if ((up_down && m_count == 0) || (!up_down && m_count == 15)) begin
                    m_co = 1;
                    if (one_shot) nmode = 0;
                end
            end else m_phase = m_phase + 1;
        end else begin
            if (pe) begin
                nmode = 0; m_count = 0; m_phase = 0;
            end else if (se) nmode = 1;
        end
        if (load) begin
            m_count = load_val;
            m_phase = 0;
        end
        m_mode = nmode;
        e.cnt = m_count; e.co = m_co; e.run = (m_mode == 1);
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = 4'(v); cycle(); load = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle, compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", int'(Count_out), e.cnt);
            chk("co", int'(Co), e.co);
            chk("running", int'(running), e.run);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = 4'h0; up_down = 1'b1; one_shot = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_count", int'(Count_out), 0);
        chk("reset_co", int'(Co), 0);
        chk("reset_running", int'(running), 0);
        rst_n = 1'b1;

        // Basic up count from reset
        pulse_start();
        cycles(10);

        // Up wrap 14 -> 15 -> 0 -> 1
        pulse_stop(); pulse_stop();
        do_load(14);
        pulse_start();
        cycles(14);

        // Down wrap 1 -> 0 -> 15
        up_down = 1'b0;
        pulse_stop(); pulse_stop();
        do_load(1);
        pulse_start();
        cycles(10);

        // Hold with frozen prescaler, resume, then clear from hold
        up_down = 1'b1;
        do_load(5);
        cycles(1);
        pulse_stop();
        cycles(20);
        pulse_start();
        cycles(3);
        pulse_stop();
        pulse_stop();
        cycles(2);

        // One-shot stop after first wrap
        one_shot = 1'b1;
        do_load(13);
        pulse_start();
        cycles(32);
        one_shot = 1'b0;

        // Load exactly on a tick cycle
        pulse_start();
        while (m_phase != PRESCALE - 1) cycle();
        do_load(9);
        cycles(2);

        // Simultaneous start and stop edges in RUN
        start = 1'b1; stop = 1'b1; cycle();
        start = 1'b0; stop = 1'b0;
        cycles(6);

        // Asynchronous reset mid-RUN at count 7
        pulse_start();
        do_load(7);
        cycles(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_count", int'(Count_out), 0);
        chk("midrun_rst_running", int'(running), 0);
        chk("midrun_rst_co", int'(Co), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = 4'($urandom_range(0, 15));
            up_down  = ($urandom_range(0, 3) != 0);
            one_shot = ($urandom_range(0, 3) == 0);
            cycle();
        end
        start = 1'b0; stop = 1'b0; load = 1'b0;
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_count_ctrl.md
Name: hex_count_ctrl

Overview:
- Upstream stage for the lab's 4-bit hex seven-segment decoder. Generates the 4-bit value `Count_out` that the decoder displays.
- Loadable 4-bit up/down counter advanced by an internal prescaler tick.
- A start/hold/clear state machine is driven by edge-detected push-button levels.
- Flags the terminal-count wrap and supports a one-shot mode that stops after one wrap.

Parameters:
- PRESCALE, 4, clock cycles per count step while running. Legal range is ≥1. Prescaler width is max(1, $clog2(PRESCALE)).

Ports:
- clk  input  1  system clock, rising edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  start/resume button level (synchronous to clk), rising-edge detected internally
- stop  input  1  hold/clear button level (synchronous to clk), rising-edge detected internally
- load  input  1  synchronous load strobe, level-sensitive
- load_val  input  4  value loaded into Count_out
- up_down  input  1  1 = count up, 0 = count down; sampled on each tick
- one_shot  input  1  1 = return to IDLE after the first wrap
- Count_out  output  4  current count, feeds the seven-segment decoder
- Co  output  1  registered one-cycle wrap pulse
- running  output  1  high while state is RUN

Behaviour:

Reset:
- rst_n low asynchronously forces:
  - Count_out = 0, Co = 0, running = 0
  - state = IDLE, prescaler = 0
  - start/stop edge registers = 0
- A button held high when rst_n releases is seen as an edge on the first clk.

Edge detection:
- start_e = start & ~start_q; stop_e = stop & ~stop_q.
- start_q and stop_q are registered every cycle.

States: IDLE, RUN, HOLD.
- IDLE:
  - prescaler held at 0; Count_out held.
  - start_e → RUN.
  - stop_e → stays IDLE and clears Count_out to 0.
- RUN:
  - prescaler increments every cycle.
  - When prescaler == PRESCALE-1, a tick occurs: prescaler ← 0 and Count_out ← Count_out ± 1 (mod 16).
  - stop_e → HOLD. The prescaler freezes at its current value and the tick in that same cycle is suppressed.
- HOLD:
  - Count_out and prescaler frozen.
  - start_e → RUN, resuming from the frozen prescaler value.
  - stop_e → IDLE with Count_out ← 0 and prescaler ← 0.

Priorities and simultaneous events:
- start_e and stop_e in the same cycle: stop_e wins.
- load = 1, any state:
  - Count_out ← load_val and prescaler ← 0 on the next edge.
  - State is unchanged. A concurrent tick is discarded and Co = 0.
  - load beats stop-clear in the same cycle; the state transition still happens.

Timing:
- running = (state == RUN), registered with the state.
- First tick occurs PRESCALE cycles after the edge that enters RUN from IDLE.
- With PRESCALE = 1, a tick occurs every RUN cycle.

Wrap and Co:
- Up-count 15→0 or down-count 0→15 on a tick sets Co = 1 for exactly the cycle in which the wrapped value is first visible. Co is 0 in all other cycles.
- up_down may change at any time and takes effect at the next tick only.
- one_shot = 1 and a wrap tick occurs: state ← IDLE in the same edge. Count_out keeps the wrapped value and running drops with Co high.
- one_shot is sampled at the wrap tick.

Reset mid-RUN:
- Immediate return to all reset values; no Co pulse.

Test Plan:
1. PRESCALE=4, rst_n low 2 cycles, release, then one start pulse with up_down=1 → running=1 one cycle later. Count_out goes 0→1→2 at 4 and 8 cycles after RUN entry; Co stays 0.
2. Load 14 (load=1 one cycle), up_down=1, start → Count_out 14, 15, 0. Co=1 only in the cycle Count_out becomes 0, then Count_out continues to 1.
3. Load 1, up_down=0, start → 1, 0, 15. Co pulses once when Count_out becomes 15.
4. RUN with prescaler at 2 and Count_out=5, stop pulse → HOLD, running=0, value 5 for 20 cycles. Start → next step to 6 arrives 2 cycles later. Second stop pulse in HOLD → IDLE, Count_out=0.
5. one_shot=1, load 13, up, start → 14, 15, 0 with Co=1 and running=0 in the same cycle. Count_out stays 0 with no further steps for 20 cycles.
6. Corner cases:
   - load=1 with load_val=9 in the exact tick cycle → Count_out=9, Co=0.
   - start and stop rising together in RUN → HOLD.
   - rst_n pulsed low mid-RUN at Count_out=7 → Count_out=0 and running=0 before the next clk edge.
